// File: rtl/div_64b_pkg.sv
// rtl/div_64b_pkg.sv - shared constants and state type for the div_64b issue stage
package div_64b_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 8;

  localparam logic [WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/div_64b.sv
// rtl/div_64b.sv - combinational exact 64-bit unsigned divide core
module div_64b
  import div_64b_pkg::*;
(
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // A zero divisor yields a defined value so no X leaks into the capture mux.
  always_comb begin
    if (divisor == '0) begin
      quotient  = '1;
      remainder = dividend;
    end else begin
      quotient  = dividend / divisor;
      remainder = dividend % divisor;
    end
  end

endmodule

// File: rtl/div_64b_issue.sv
// rtl/div_64b_issue.sv - issue/capture stage driving div_64b as a multicycle path
module div_64b_issue
  import div_64b_pkg::state_t, div_64b_pkg::IDLE, div_64b_pkg::SETTLE, div_64b_pkg::HOLD,
         div_64b_pkg::CNT_W, div_64b_pkg::DBZ_QUOTIENT;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned WIDTH         = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             dbz
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   core_quo;
  logic [WIDTH-1:0]   core_rem;

  div_64b u_core (opa_q, opb_q, core_quo, core_rem);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = in0;
          opb_d   = in1;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Zero divisor bypasses the core so approximate variants cannot corrupt it.
          if (opb_q == '0) begin
            quo_d = DBZ_QUOTIENT;
            rem_d = opa_q;
            dbz_d = 1'b1;
          end else begin
            quo_d = core_quo;
            rem_d = core_rem;
            dbz_d = 1'b0;
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out0      = quo_q;
  assign out1      = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_64b_issue.sv
// tb/tb_div_64b_issue.sv - directed and back-to-back checks of div_64b_issue
module tb_div_64b_issue;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: SETTLE_CYCLES = 2
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_dbz;
  logic [63:0] a_in0 = '0, a_in1 = '0, a_out0, a_out1;
  // Instances B (SETTLE_CYCLES = 1) and C (SETTLE_CYCLES = 4) share data inputs
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_dbz;
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_dbz;
  logic        bc_out_ready = 1'b1;
  logic [63:0] bc_in0 = '0, bc_in1 = '0, b_out0, b_out1, c_out0, c_out1;

  div_64b_issue #(.SETTLE_CYCLES(2), .WIDTH(64)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in0(a_in0), .in1(a_in1), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out0(a_out0), .out1(a_out1), .dbz(a_dbz));

  div_64b_issue #(.SETTLE_CYCLES(1), .WIDTH(64)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in0(bc_in0), .in1(bc_in1), .out_valid(b_out_valid), .out_ready(bc_out_ready),
    .out0(b_out0), .out1(b_out1), .dbz(b_dbz));

  div_64b_issue #(.SETTLE_CYCLES(4), .WIDTH(64)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in0(bc_in0), .in1(bc_in1), .out_valid(c_out_valid), .out_ready(bc_out_ready),
    .out0(c_out0), .out1(c_out1), .dbz(c_dbz));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, " out_valid"}, {63'd0, a_out_valid}, 64'd0);
    check({tag, " out0"}, a_out0, 64'd0);
    check({tag, " out1"}, a_out1, 64'd0);
    check({tag, " dbz"}, {63'd0, a_dbz}, 64'd0);
  endtask

  // One operation on instance A; bp = cycles of backpressure with toggling inputs.
  task automatic op_a(input string tag, input logic [63:0] n, input logic [63:0] d,
                      input logic [63:0] eq, input logic [63:0] er, input logic ez,
                      input int bp);
    int waited = 0;
    @(negedge clk);
    while (!a_in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " ready before accept"}, {63'd0, a_in_ready}, 64'd1);
    a_in_valid  = 1'b1;
    a_in0       = n;
    a_in1       = d;
    a_out_ready = 1'b0;
    @(negedge clk);                      // after E0
    a_in_valid = 1'b0;
    check({tag, " valid E0"}, {63'd0, a_out_valid}, 64'd0);
    check({tag, " in_ready E0"}, {63'd0, a_in_ready}, 64'd0);
    @(negedge clk);                      // after E1
    check({tag, " valid E1"}, {63'd0, a_out_valid}, 64'd0);
    @(negedge clk);                      // after E2
    check({tag, " valid E2"}, {63'd0, a_out_valid}, 64'd1);
    check({tag, " out0"}, a_out0, eq);
    check({tag, " out1"}, a_out1, er);
    check({tag, " dbz"}, {63'd0, a_dbz}, {63'd0, ez});
    check({tag, " in_ready hold"}, {63'd0, a_in_ready}, 64'd0);
    for (int i = 0; i < bp; i++) begin
      a_in_valid = 1'b1;
      a_in0      = {$urandom, $urandom};
      a_in1      = {$urandom, $urandom};
      @(negedge clk);
      check({tag, " bp valid"}, {63'd0, a_out_valid}, 64'd1);
      check({tag, " bp out0"}, a_out0, eq);
      check({tag, " bp out1"}, a_out1, er);
      check({tag, " bp dbz"}, {63'd0, a_dbz}, {63'd0, ez});
      check({tag, " bp in_ready"}, {63'd0, a_in_ready}, 64'd0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);                      // after release edge
    a_out_ready = 1'b0;
    check({tag, " valid after release"}, {63'd0, a_out_valid}, 64'd0);
    check({tag, " in_ready after release"}, {63'd0, a_in_ready}, 64'd1);
    check({tag, " out0 kept"}, a_out0, eq);
    @(negedge clk);
    check({tag, " still idle"}, {63'd0, a_in_ready}, 64'd1);
  endtask

  // Back-to-back with out_ready high on instance B (s=1) or C (s=4).
  task automatic back_to_back(input int s, input int total);
    logic [128:0] exp_q[$];
    logic [128:0] got, want;
    logic [63:0]  n, d;
    logic         pending = 1'b0;
    logic         rdy, vld;
    int           accepts = 0, results = 0, t = 0, last_t = -1;
    int           budget = total * (s + 2) + 50;
    string        tag = (s == 1) ? "b2b s1" : "b2b s4";
    @(negedge clk);
    bc_in0 = 64'd1000;
    bc_in1 = 64'd7;
    if (s == 1) b_in_valid = 1'b1; else c_in_valid = 1'b1;
    while (results < total && t < budget) begin
      if (pending) begin
        pending = 1'b0;
        if (accepts == total) begin
          b_in_valid = 1'b0;
          c_in_valid = 1'b0;
        end else begin
          n = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 65535));
          case ($urandom_range(0, 9))
            0:       d = 64'd0;
            1, 2, 3: d = 64'($urandom_range(1, 300));
            default: d = {$urandom, $urandom};
          endcase
          bc_in0 = n;
          bc_in1 = d;
        end
      end
      vld = (s == 1) ? b_out_valid : c_out_valid;
      rdy = (s == 1) ? b_in_ready  : c_in_ready;
      if (vld) begin
        got = (s == 1) ? {b_dbz, b_out0, b_out1} : {c_dbz, c_out0, c_out1};
        if (exp_q.size() == 0) begin
          check({tag, " unexpected result"}, 64'd1, 64'd0);
        end else begin
          want = exp_q.pop_front();
          check({tag, " quotient"}, got[127:64], want[127:64]);
          check({tag, " remainder"}, got[63:0], want[63:0]);
          check({tag, " dbz"}, {63'd0, got[128]}, {63'd0, want[128]});
        end
        results++;
      end
      if (rdy && accepts < total) begin
        if (bc_in1 == 64'd0) exp_q.push_back({1'b1, ONES, bc_in0});
        else                 exp_q.push_back({1'b0, bc_in0 / bc_in1, bc_in0 % bc_in1});
        if (last_t >= 0) check({tag, " accept spacing"}, 64'(t - last_t), 64'(s + 2));
        last_t = t;
        accepts++;
        pending = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    b_in_valid = 1'b0;
    c_in_valid = 1'b0;
    check({tag, " result count"}, 64'(results), 64'(total));
    check({tag, " queue drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset in_ready", {63'd0, a_in_ready}, 64'd0);
    check_idle_a("reset");
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", {63'd0, a_in_ready}, 64'd1);
    check_idle_a("post reset");

    op_a("100/7",     64'd100,   64'd7,  64'd14, 64'd2,     1'b0, 0);
    op_a("12345/0",   64'd12345, 64'd0,  ONES,   64'd12345, 1'b1, 0);
    op_a("max/1",     ONES,      64'd1,  ONES,   64'd0,     1'b0, 0);
    op_a("5/max",     64'd5,     ONES,   64'd0,  64'd5,     1'b0, 0);
    op_a("77/5 bp",   64'd77,    64'd5,  64'd15, 64'd2,     1'b0, 6);

    // Reset one cycle into SETTLE discards 1000/3.
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in0      = 64'd1000;
    a_in1      = 64'd3;
    @(negedge clk);
    a_in_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    check("mid-settle reset in_ready", {63'd0, a_in_ready}, 64'd0);
    check_idle_a("mid-settle reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("aborted op no valid", {63'd0, a_out_valid}, 64'd0);
    end
    op_a("9/4", 64'd9, 64'd4, 64'd2, 64'd1, 1'b0, 0);

    back_to_back(1, 1000);
    back_to_back(4, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_64b_issue.md
# div_64b_issue

Sequential issue/capture stage wrapped around the combinational `div_64b` core. It accepts a dividend/divisor pair over a valid/ready handshake and holds the operands stable at the core inputs for a programmable settle window. It then registers the quotient/remainder (or a divide-by-zero result) and presents them downstream over a second valid/ready handshake. It lets the exact and approximate `div_64b` variants be driven as multicycle paths in clocked system and benchmark harnesses.

## Interface
- `SETTLE_CYCLES`, 2, number of clock edges operands are held at the core before results are captured; legal range 1..255.
- `WIDTH`, 64, operand/result width; fixed at 64 for `div_64b`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: an operand pair is present on `in0`/`in1`.
- `in_ready` output 1: the stage can accept an operand pair.
- `in0` input 64: dividend, unsigned.
- `in1` input 64: divisor, unsigned.
- `out_valid` output 1: the result registers hold a valid result.
- `out_ready` input 1: downstream accepts the result.
- `out0` output 64: quotient.
- `out1` output 64: remainder.
- `dbz` output 1: the captured result came from a zero divisor.

## Operation
- Three states: IDLE, SETTLE, HOLD. Reset enters IDLE.
- IDLE:
  - `in_ready`=1.
  - On an edge with `in_valid`: register `in0`/`in1` into the operand regs, load `cnt` = SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - `in_ready`=0 and the operand regs are frozen.
  - Each edge: if `cnt`≠0, decrement `cnt`. If `cnt`=0, capture results and go to HOLD.
- Capture rules:
  - Divisor ≠ 0: `out0`/`out1` take the core's quotient/remainder; `dbz`=0.
  - Divisor = 0: the core output is ignored. `out0`=64'hFFFF_FFFF_FFFF_FFFF, `out1`=dividend, `dbz`=1.
- HOLD:
  - `out_valid`=1; `out0`/`out1`/`dbz` are stable.
  - An edge with `out_ready` clears `out_valid` and returns to IDLE.
- Unsigned arithmetic only. No sign handling and no rounding.
- The core result is used as-is; approximate variants may violate q·d+r=n, and the stage does not check this.
- `in_valid` in SETTLE/HOLD is ignored; the upstream must hold it until `in_ready`.

## Timing
- Reset values:
  - `out_valid`=0, `out0`=0, `out1`=0, `dbz`=0, operand regs=0, `cnt`=0.
  - `in_ready`=0 while `rst` is high; it is 1 in the first cycle after `rst` falls.
- Latency: with accept on edge E0, `out_valid` is high after edge E0+SETTLE_CYCLES.
- Zero-divisor results have the same latency as normal results.
- Throughput with `out_ready` held high: one result per SETTLE_CYCLES+2 cycles.
  - The release edge returns the stage to IDLE, costing one `in_ready` bubble before the next accept.
- `in_ready` is a function of state only. It never depends combinationally on `in_valid` or `out_ready`.
- Backpressure: HOLD lasts indefinitely while `out_ready`=0, and outputs do not change.
- Reset mid-operation (any state) discards the operands and result. No `out_valid` pulse occurs for the aborted operation.
- SETTLE_CYCLES=1: capture happens on the first edge after accept.

## Structure
- Shared package `div_64b_pkg`:
  - `WIDTH`
  - the state enum `{IDLE, SETTLE, HOLD}`
  - `DBZ_QUOTIENT` = all ones
  - the width of `cnt` (8 bits)
- One sub-module: the existing `div_64b` core, instantiated as-is with positional order (dividend, divisor, quotient, remainder).
  - Its inputs come from the operand regs only.
- No other hierarchy. Counter, FSM, and capture muxing are inline.

## Test plan
- Basic division, SETTLE_CYCLES=2: accept 100/7 at E0 → `out_valid` after E2 with `out0`=14, `out1`=2, `dbz`=0; release when `out_ready`=1 → `in_ready`=1 the following cycle.
- Zero divisor: 12345/0 → `out0`=all ones, `out1`=12345, `dbz`=1, at the same latency as a normal divide.
- Extremes: (2^64-1)/1 → `out0`=2^64-1, `out1`=0; 5/(2^64-1) → `out0`=0, `out1`=5.
- Backpressure and input stability, as one sequence:
  - Hold `out_ready`=0 for 6 cycles after `out_valid` rises.
  - Toggle `in0`/`in1` and hold `in_valid`=1 throughout.
  - Required: outputs stay constant, `in_ready`=0, and no new operands are accepted.
- Reset mid-SETTLE: assert `rst` one cycle after accepting 1000/3 → `out_valid` never rises for it, all outputs read 0, and the next op 9/4 returns 2, 1.
- Back-to-back with `out_ready` tied high, SETTLE_CYCLES=1 and 4: accepts occur every 3 and 6 cycles respectively, and results match `div_64b` over 1000 random pairs.
